// File: rtl/lab_pkg.sv
// lab_pkg: constants and helpers shared by the lab input-conditioning blocks.
//   DEB_CYCLES_DEF  - default debounce length in clock cycles
//   SYNC_STAGES_DEF - default synchronizer depth
//   clog2()         - constant function used to size the debounce counters
package lab_pkg;

    localparam int unsigned DEB_CYCLES_DEF  = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // Bits needed to hold 0..value-1; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/deb_bit.sv
// deb_bit: one bit of the input conditioner -- synchronizer chain, debounce
// counter, stable-value flop and registered rise/fall pulses.
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   raw_i   - unsynchronized level
//   d_o     - debounced stable value
//   rise_o  - one-cycle pulse, coincident with d_o going 0->1
//   fall_o  - one-cycle pulse, coincident with d_o going 1->0
module deb_bit
    import lab_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic d_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = clog2(DEB_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_s;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
        sync_s   = sync_q[SYNC_STAGES-1];
        cnt_d    = '0;
        stable_d = stable_q;
        // Any agreement clears the counter; the DEB_CYCLES-th consecutive
        // disagreement accepts the new level and also restarts from zero.
        if (sync_s != stable_q) begin
            if (cnt_q == CntMax) begin
                stable_d = sync_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = stable_d & ~stable_q;
        fall_d = ~stable_d & stable_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign d_o    = stable_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/in4_debounce.sv
// in4_debounce: synchronizes and debounces WIDTH raw switch/button levels,
// bit by bit, to feed the d input of the lab 4-bit register.
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-low reset
//   raw    - unsynchronized switch/button levels
//   d_out  - debounced stable word
//   valid  - one-cycle pulse when any bit of d_out changes
//   rise   - per-bit one-cycle pulse on a 0->1 change of d_out
//   fall   - per-bit one-cycle pulse on a 1->0 change of d_out
// Build option: define IN4_INVERT_EN to invert raw ahead of the
// synchronizers (active-low pushbuttons; d_out=1 means pressed).
module in4_debounce
    import lab_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] d_out,
    output logic             valid,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] raw_c;

`ifdef IN4_INVERT_EN
    assign raw_c = ~raw;
`else
    assign raw_c = raw;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        deb_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_deb_bit (
            .clk_i  (clk),
            .rst_ni (rst),
            .raw_i  (raw_c[i]),
            .d_o    (d_out[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    // Pulses are already registered, so valid inherits their one-cycle timing.
    assign valid = |(rise | fall);

endmodule
